// File: rtl/i2c_cfg_pkg.sv
// Shared types and constants for the I2C boot-time configuration sequencer.
// Table entries are {slave_addr+W, reg_addr, data}; an all-ones entry ends the table.
package i2c_cfg_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StFetch,
    StWaitRom,
    StIssue,
    StWaitXfer,
    StGap,
    StDone,
    StError
  } state_e;

  localparam logic [23:0] END_MARKER = 24'hFF_FFFF;

  localparam int unsigned SLV_HI = 23;
  localparam int unsigned SLV_LO = 16;
  localparam int unsigned REG_HI = 15;
  localparam int unsigned REG_LO = 8;
  localparam int unsigned DAT_HI = 7;
  localparam int unsigned DAT_LO = 0;

endpackage

// File: rtl/i2c_gap_timer.sv
// Bus-idle gap timer: load arms a down-count of GAP_CYCLES; expired flags the
// final cycle of the gap so the owner can leave its gap state on that edge.
module i2c_gap_timer #(
  parameter int unsigned GAP_CYCLES = 250
) (
  input  logic clk,
  input  logic reset_n,
  input  logic load,
  output logic expired
);

  localparam int unsigned CntW = $clog2(GAP_CYCLES + 1);

  logic [CntW-1:0] cnt_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q <= '0;
    end else if (load) begin
      cnt_q <= CntW'(GAP_CYCLES);
    end else if (cnt_q != '0) begin
      cnt_q <= cnt_q - CntW'(1);
    end
  end

  assign expired = (cnt_q == CntW'(1));

endmodule

// File: rtl/i2c_cfg_sequencer.sv
// Boot-time configuration sequencer: walks the config ROM, hands each entry to the
// I2C write engine, retries NACKed writes and reports sticky done/error status.
module i2c_cfg_sequencer
  import i2c_cfg_pkg::*;
#(
  parameter int unsigned NUM_ENTRIES = 20,
  parameter int unsigned IDX_W       = 6,
  parameter int unsigned MAX_RETRY   = 3,
  parameter int unsigned GAP_CYCLES  = 250
) (
  input  logic             CLK,
  input  logic             reset_n,
  input  logic             start_n,
  output logic [IDX_W-1:0] tbl_addr,
  input  logic [23:0]      tbl_data,
  output logic             xfer_req,
  output logic [23:0]      xfer_data,
  input  logic             xfer_done,
  input  logic             xfer_nack,
  output logic             busy,
  output logic             done,
  output logic             error,
  output logic [IDX_W-1:0] err_index
);

  localparam int unsigned RetryW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

  state_e              state_q, state_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic [RetryW-1:0]   cnt_q, cnt_d;
  logic [23:0]         data_q, data_d;
  logic                done_q, done_d;
  logic                error_q, error_d;
  logic [IDX_W-1:0]    eidx_q, eidx_d;
  logic                gap_load;
  logic                gap_expired;

  i2c_gap_timer #(
    .GAP_CYCLES(GAP_CYCLES)
  ) u_gap_timer (
    .clk    (CLK),
    .reset_n(reset_n),
    .load   (gap_load),
    .expired(gap_expired)
  );

  always_ff @(posedge CLK or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= StIdle;
      idx_q   <= '0;
      cnt_q   <= '0;
      data_q  <= '0;
      done_q  <= 1'b0;
      error_q <= 1'b0;
      eidx_q  <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
      done_q  <= done_d;
      error_q <= error_d;
      eidx_q  <= eidx_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    cnt_d    = cnt_q;
    data_d   = data_q;
    done_d   = done_q;
    error_d  = error_q;
    eidx_d   = eidx_q;
    gap_load = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (!start_n) begin
          idx_d   = '0;
          cnt_d   = '0;
          done_d  = 1'b0;
          error_d = 1'b0;
          eidx_d  = '0;
          state_d = StFetch;
        end
      end
      StFetch:   state_d = StWaitRom;
      StWaitRom: begin
        if (tbl_data == END_MARKER) begin
          done_d  = 1'b1;
          state_d = StDone;
        end else begin
          data_d  = {tbl_data[SLV_HI:SLV_LO], tbl_data[REG_HI:REG_LO], tbl_data[DAT_HI:DAT_LO]};
          state_d = StIssue;
        end
      end
      StIssue:   state_d = StWaitXfer;
      StWaitXfer: begin
        if (xfer_done) begin
          if (!xfer_nack) begin
            cnt_d    = '0;
            idx_d    = idx_q + IDX_W'(1);
            gap_load = 1'b1;
            state_d  = StGap;
          end else if (cnt_q < RetryW'(MAX_RETRY)) begin
            // Same index is re-fetched after the gap.
            cnt_d    = cnt_q + RetryW'(1);
            gap_load = 1'b1;
            state_d  = StGap;
          end else begin
            error_d = 1'b1;
            eidx_d  = idx_q;
            state_d = StError;
          end
        end
      end
      StGap: begin
        if (gap_expired) begin
          if (idx_q == IDX_W'(NUM_ENTRIES)) begin
            done_d  = 1'b1;
            state_d = StDone;
          end else begin
            state_d = StFetch;
          end
        end
      end
      StDone, StError: state_d = StIdle;
      default:         state_d = StIdle;
    endcase
  end

  always_comb begin
    tbl_addr  = idx_q;
    xfer_req  = (state_q == StIssue) || (state_q == StWaitXfer);
    xfer_data = data_q;
    busy      = (state_q != StIdle) && (state_q != StDone) && (state_q != StError);
    done      = done_q;
    error     = error_q;
    err_index = eidx_q;
  end

endmodule

// File: tb/tb_i2c_cfg_sequencer.sv
// Bench for i2c_cfg_sequencer: a timeline model predicts every output per cycle from
// the table contents, engine latencies and NACK plan; a compare process checks them.
module tb_i2c_cfg_sequencer;

  localparam int unsigned NE = 20;
  localparam int unsigned IW = 6;
  localparam int unsigned MR = 3;
  localparam int unsigned G  = 12;
  localparam int MaxCyc = 16384;
  localparam logic [23:0] EndMk = 24'hFF_FFFF;

  logic          CLK = 1'b0;
  logic          reset_n = 1'b0;
  logic          start_n = 1'b1;
  logic          xfer_done = 1'b0;
  logic          xfer_nack = 1'b0;
  logic [23:0]   tbl_data = '0;
  logic [IW-1:0] tbl_addr;
  logic [IW-1:0] err_index;
  logic [23:0]   xfer_data;
  logic          xfer_req, busy, done, error;

  i2c_cfg_sequencer #(
    .NUM_ENTRIES(NE),
    .IDX_W      (IW),
    .MAX_RETRY  (MR),
    .GAP_CYCLES (G)
  ) dut (
    .CLK      (CLK),
    .reset_n  (reset_n),
    .start_n  (start_n),
    .tbl_addr (tbl_addr),
    .tbl_data (tbl_data),
    .xfer_req (xfer_req),
    .xfer_data(xfer_data),
    .xfer_done(xfer_done),
    .xfer_nack(xfer_nack),
    .busy     (busy),
    .done     (done),
    .error    (error),
    .err_index(err_index)
  );

  always #5 CLK = ~CLK;

  logic [23:0] rom[64];
  int          nacks[64];
  always @(posedge CLK) tbl_data <= rom[tbl_addr];

  bit            chk_en[MaxCyc];
  bit            exp_req[MaxCyc];
  bit            exp_busy[MaxCyc];
  bit            exp_done[MaxCyc];
  bit            exp_error[MaxCyc];
  logic [23:0]   exp_data[MaxCyc];
  logic [IW-1:0] exp_eidx[MaxCyc];
  bit            drv_start[MaxCyc];
  bit            drv_done[MaxCyc];
  bit            drv_nack[MaxCyc];

  bit            m_done = 1'b0;
  bit            m_error = 1'b0;
  logic [IW-1:0] m_eidx = '0;
  int cyc = 0;
  int checks = 0;
  int errors = 0;
  int first_req = 0;
  int force_lat = 0;
  int rst_at = -1;
  int rel_at = -1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got 0x%0h, expected 0x%0h", name, cyc, act, exp);
    end
  endtask

  function automatic void fill(int from, int to, bit req, bit bsy, logic [23:0] d);
    for (int c = from; c <= to; c++) begin
      chk_en[c]    = 1'b1;
      exp_req[c]   = req;
      exp_busy[c]  = bsy;
      exp_data[c]  = d;
      exp_done[c]  = m_done;
      exp_error[c] = m_error;
      exp_eidx[c]  = m_eidx;
    end
  endfunction

  function automatic logic [23:0] rand_entry();
    logic [23:0] v;
    v = 24'($urandom);
    if (v == EndMk) v = 24'h12_3456;
    return v;
  endfunction

  // Timeline of one sequence whose start_n is low in cycle s; e is the DONE/ERROR cycle.
  task automatic plan_seq(input int s, output int e);
    int t, idx, cnt, lat, dc;
    bit nk, first;
    t = s + 1; idx = 0; cnt = 0; first = 1'b1; e = -1;
    m_done = 1'b0; m_error = 1'b0; m_eidx = '0;
    while (e < 0) begin
      fill(t, t + 1, 1'b0, 1'b1, '0);
      if (rom[idx] == EndMk) begin
        m_done = 1'b1;
        fill(t + 2, t + 2, 1'b0, 1'b0, '0);
        e = t + 2;
      end else begin
        lat = (first && force_lat > 0) ? force_lat : int'($urandom_range(6, 1));
        if (first) first_req = t + 2;
        first = 1'b0;
        dc = t + 2 + lat;
        fill(t + 2, dc, 1'b1, 1'b1, rom[idx]);
        nk = (cnt < nacks[idx]);
        drv_done[dc] = 1'b1;
        drv_nack[dc] = nk;
        if (nk && cnt >= int'(MR)) begin
          m_error = 1'b1;
          m_eidx  = IW'(idx);
          fill(dc + 1, dc + 1, 1'b0, 1'b0, '0);
          e = dc + 1;
        end else begin
          if (nk) cnt++;
          else begin idx++; cnt = 0; end
          fill(dc + 1, dc + G, 1'b0, 1'b1, '0);
          // Stray done during the gap must be ignored.
          if ($urandom_range(1, 0) == 1) begin
            drv_done[dc + 1 + int'($urandom_range(G - 1, 0))] = 1'b1;
          end
          t = dc + G + 1;
          if (idx == int'(NE)) begin
            m_done = 1'b1;
            fill(t, t, 1'b0, 1'b0, '0);
            e = t;
          end
        end
      end
    end
  endtask

  task automatic run_scn(input int lead, output int s, output int e);
    s = cyc + lead;
    fill(cyc + 1, s, 1'b0, 1'b0, '0);
    drv_start[s] = 1'b1;
    plan_seq(s, e);
  endtask

  task automatic step();
    @(posedge CLK);
    cyc++;
    #1;
    start_n   = !drv_start[cyc];
    xfer_done = drv_done[cyc];
    xfer_nack = drv_done[cyc] ? drv_nack[cyc] : 1'($urandom_range(1, 0));
    if (cyc == rel_at) reset_n = 1'b1;
    if (cyc == rst_at) begin
      #1 reset_n = 1'b0;
      #1;
      chk("rst_xfer_req", 32'(xfer_req), 32'd0);
      chk("rst_tbl_addr", 32'(tbl_addr), 32'd0);
      chk("rst_xfer_data", 32'(xfer_data), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
    end
  endtask

  task automatic run_to(input int n);
    while (cyc < n) step();
  endtask

  always @(negedge CLK) begin
    if (cyc < MaxCyc && chk_en[cyc]) begin
      chk("xfer_req", 32'(xfer_req), 32'(exp_req[cyc]));
      chk("busy", 32'(busy), 32'(exp_busy[cyc]));
      chk("done", 32'(done), 32'(exp_done[cyc]));
      chk("error", 32'(error), 32'(exp_error[cyc]));
      chk("err_index", 32'(err_index), 32'(exp_eidx[cyc]));
      if (exp_req[cyc]) chk("xfer_data", 32'(xfer_data), 32'(exp_data[cyc]));
    end
  end

  int rises = 0, last_addr = 0, gap_meas = 0, last_done_cyc = 0, busy_cyc = 0;
  bit prev_req = 1'b0;
  always @(negedge CLK) begin
    if (xfer_req && !prev_req) begin
      rises     <= rises + 1;
      last_addr <= int'(tbl_addr);
      gap_meas  <= cyc - last_done_cyc;
    end
    if (xfer_req && xfer_done) last_done_cyc <= cyc;
    busy_cyc <= busy_cyc + int'(busy);
    prev_req <= xfer_req;
  end

  initial begin
    int s, e, e2, r0, b0, r, late;
    for (int i = 0; i < 64; i++) begin
      rom[i]   = rand_entry();
      nacks[i] = 0;
    end

    // Reset state
    rel_at = 3;
    fill(1, 6, 1'b0, 1'b0, '0);
    run_to(2);
    chk("reset_tbl_addr", 32'(tbl_addr), 32'd0);
    chk("reset_xfer_req", 32'(xfer_req), 32'd0);
    chk("reset_done", 32'(done), 32'd0);
    run_to(6);

    // Nominal three entries, then a second run started by start_n held across DONE
    rom[3] = EndMk;
    r0 = rises;
    run_scn(2, s, e);
    for (int c = e - 2; c <= e + 1; c++) drv_start[c] = 1'b1;
    fill(e + 1, e + 1, 1'b0, 1'b0, '0);
    plan_seq(e + 1, e2);
    fill(e2 + 1, e2 + 4, 1'b0, 1'b0, '0);
    run_to(e);
    chk("nominal_reqs", 32'(rises - r0), 32'd3);
    chk("nominal_done", 32'(done), 32'd1);
    chk("nominal_error", 32'(error), 32'd0);
    run_to(e2 + 4);
    chk("held_start_reqs", 32'(rises - r0), 32'd6);

    // Entry 1 NACKed twice
    nacks[1] = 2;
    r0 = rises;
    run_scn(2, s, e);
    fill(e + 1, e + 4, 1'b0, 1'b0, '0);
    run_to(e + 4);
    chk("retry_reqs", 32'(rises - r0), 32'd5);
    chk("retry_done", 32'(done), 32'd1);
    nacks[1] = 0;

    // Entry 2 always NACKs
    nacks[2] = 99;
    r0 = rises;
    run_scn(2, s, e);
    fill(e + 1, e + 4, 1'b0, 1'b0, '0);
    run_to(e + 4);
    chk("fail_reqs", 32'(rises - r0), 32'd6);
    chk("fail_error", 32'(error), 32'd1);
    chk("fail_err_index", 32'(err_index), 32'd2);
    chk("fail_busy", 32'(busy), 32'd0);
    nacks[2] = 0;

    // Full table without marker
    rom[3] = rand_entry();
    r0 = rises;
    run_scn(2, s, e);
    fill(e + 1, e + 4, 1'b0, 1'b0, '0);
    run_to(e + 4);
    chk("full_reqs", 32'(rises - r0), 32'd20);
    chk("full_last_addr", 32'(last_addr), 32'd19);
    chk("full_done", 32'(done), 32'd1);

    // Marker at index 0
    rom[0] = EndMk;
    r0 = rises;
    b0 = busy_cyc;
    run_scn(2, s, e);
    fill(e + 1, e + 4, 1'b0, 1'b0, '0);
    run_to(e + 4);
    chk("empty_busy_cycles", 32'(busy_cyc - b0), 32'd2);
    chk("empty_reqs", 32'(rises - r0), 32'd0);
    chk("empty_done", 32'(done), 32'd1);
    rom[0] = rand_entry();

    // Reset in the 5th WAIT_XFER cycle, then a late xfer_done
    rom[3] = EndMk;
    r0 = rises;
    force_lat = 20;
    run_scn(2, s, e);
    force_lat = 0;
    r = first_req + 5;
    late = first_req + 20;
    for (int c = r; c <= e + 4; c++) begin
      drv_done[c] = 1'b0;
      drv_nack[c] = 1'b0;
      drv_start[c] = 1'b0;
    end
    drv_done[late] = 1'b1;
    rst_at = r;
    rel_at = r + 2;
    m_done = 1'b0; m_error = 1'b0; m_eidx = '0;
    fill(r, late + 10, 1'b0, 1'b0, '0);
    run_to(late + 10);
    chk("reset_mid_reqs", 32'(rises - r0), 32'd1);
    chk("reset_mid_done", 32'(done), 32'd0);

    // start_n pulses mid-sequence; gap from done to next request
    r0 = rises;
    run_scn(2, s, e);
    drv_start[s + 4] = 1'b1;
    drv_start[s + int'(G) + 6] = 1'b1;
    fill(e + 1, e + 4, 1'b0, 1'b0, '0);
    run_to(e + 4);
    chk("midstart_reqs", 32'(rises - r0), 32'd3);
    chk("gap_len", 32'(gap_meas), 32'(G + 3));
    chk("midstart_done", 32'(done), 32'd1);

    // Randomized tables and NACK plans
    for (int k = 0; k < 6; k++) begin
      int mk, v;
      for (int i = 0; i < 64; i++) begin
        rom[i] = rand_entry();
        v = int'($urandom_range(9, 0));
        nacks[i] = (v <= 5) ? 0 : (v == 9) ? 99 : v - 5;
      end
      mk = int'($urandom_range(24, 0));
      if (mk < int'(NE)) rom[mk] = EndMk;
      run_scn(int'($urandom_range(5, 2)), s, e);
      fill(e + 1, e + 4, 1'b0, 1'b0, '0);
      run_to(e + 4);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
